// File: rtl/cyclotron_trace_pkg.sv
// Shared widths, queue entry layout and slot helper for the cyclotron trace collector.
package cyclotron_trace_pkg;

   localparam int DEF_ARCH_LEN     = 32;
   localparam int DEF_NUM_WARPS    = 8;
   localparam int DEF_NUM_LANES    = 16;
   localparam int DEF_REG_BITS     = 8;
   localparam int DEF_DEPTH        = 4;
   localparam int DEF_WARP_ID_BITS = $clog2(DEF_NUM_WARPS);
   localparam int DEF_DATA_W       = DEF_NUM_LANES * DEF_ARCH_LEN;
   localparam int NUM_SLOTS        = 3;

   // One captured register writeback.
   typedef struct packed {
      logic [DEF_REG_BITS-1:0] address;
      logic [DEF_DATA_W-1:0]   data;
   } trace_slot_t;

   // One pending commit waiting for its writebacks (default widths).
   typedef struct packed {
      logic [DEF_ARCH_LEN-1:0]     pc;
      logic [DEF_WARP_ID_BITS-1:0] warp_id;
      logic [DEF_NUM_LANES-1:0]    tmask;
      logic [1:0]                  n_writes;
      logic [1:0]                  wb_count;
      trace_slot_t [NUM_SLOTS-1:0] regs;
   } trace_entry_t;

   // A writeback slot carries data only when its index is below the expected write count.
   function automatic logic slot_enabled(input logic [1:0] n_writes, input logic [1:0] slot);
      return (slot < n_writes);
   endfunction

endpackage

// File: rtl/cyclotron_trace_collector_if.sv
// Commit / writeback / trace bundle between the core, the collector and the difftest sink.
interface cyclotron_trace_collector_if #(
   parameter int ARCH_LEN  = 32,
   parameter int NUM_WARPS = 8,
   parameter int NUM_LANES = 16,
   parameter int REG_BITS  = 8
);
   localparam int WARP_ID_BITS = $clog2(NUM_WARPS);
   localparam int DATA_W       = NUM_LANES * ARCH_LEN;

   logic                    commit_valid;
   logic                    commit_ready;
   logic [ARCH_LEN-1:0]     commit_pc;
   logic [WARP_ID_BITS-1:0] commit_warpId;
   logic [NUM_LANES-1:0]    commit_tmask;
   logic [1:0]              commit_nWrites;

   logic                    wb_valid;
   logic [REG_BITS-1:0]     wb_address;
   logic [DATA_W-1:0]       wb_data;

   logic                    trace_valid;
   logic [ARCH_LEN-1:0]     trace_pc;
   logic [WARP_ID_BITS-1:0] trace_warpId;
   logic [NUM_LANES-1:0]    trace_tmask;
   logic                    trace_regs_0_enable;
   logic [REG_BITS-1:0]     trace_regs_0_address;
   logic [DATA_W-1:0]       trace_regs_0_data;
   logic                    trace_regs_1_enable;
   logic [REG_BITS-1:0]     trace_regs_1_address;
   logic [DATA_W-1:0]       trace_regs_1_data;
   logic                    trace_regs_2_enable;
   logic [REG_BITS-1:0]     trace_regs_2_address;
   logic [DATA_W-1:0]       trace_regs_2_data;
   logic [31:0]             trace_count;
   logic                    err_orphan_wb;

   // Core side: produces commits and writebacks, observes the trace.
   modport master (
      output commit_valid, commit_pc, commit_warpId, commit_tmask, commit_nWrites,
      output wb_valid, wb_address, wb_data,
      input  commit_ready,
      input  trace_valid, trace_pc, trace_warpId, trace_tmask,
      input  trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
      input  trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
      input  trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
      input  trace_count, err_orphan_wb
   );

   // Collector side.
   modport slave (
      input  commit_valid, commit_pc, commit_warpId, commit_tmask, commit_nWrites,
      input  wb_valid, wb_address, wb_data,
      output commit_ready,
      output trace_valid, trace_pc, trace_warpId, trace_tmask,
      output trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
      output trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
      output trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
      output trace_count, err_orphan_wb
   );

endinterface

// File: rtl/cyclotron_trace_fifo.sv
// Synchronous pending-commit queue with an in-place write port on the head entry.
module cyclotron_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_head_wr,
   input  logic [WIDTH-1:0] i_head_data,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_head_wr;

   // Guard every operation against the registered occupancy so the queue can never corrupt itself.
   always_comb begin
      w_empty   = (r_count == CNT_W'(0));
      w_full    = (r_count == CNT_W'(DEPTH));
      w_push    = i_push && !w_full;
      w_pop     = i_pop && !w_empty;
      w_head_wr = i_head_wr && !w_empty;
   end

   // Storage: push writes the tail, head update rewrites the head (never the same slot, since push needs not-full and head write needs not-empty).
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
         end
         if (w_head_wr) begin
            r_mem[r_rd_ptr] <= i_head_data;
         end
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/cyclotron_trace_collector.sv
// Pairs retired instructions with their register writebacks and emits one trace record per commit, in commit order.
module cyclotron_trace_collector
   import cyclotron_trace_pkg::*;
#(
   parameter int ARCH_LEN  = DEF_ARCH_LEN,
   parameter int NUM_WARPS = DEF_NUM_WARPS,
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int REG_BITS  = DEF_REG_BITS,
   parameter int DEPTH     = DEF_DEPTH
) (
   input logic clock,
   input logic reset_n,
   cyclotron_trace_collector_if.slave bus
);

   localparam int WARP_ID_BITS = $clog2(NUM_WARPS);
   localparam int DATA_W       = NUM_LANES * ARCH_LEN;
   localparam int CNT_W        = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [REG_BITS-1:0] address;
      logic [DATA_W-1:0]   data;
   } slot_t;

   typedef struct packed {
      logic [ARCH_LEN-1:0]     pc;
      logic [WARP_ID_BITS-1:0] warp_id;
      logic [NUM_LANES-1:0]    tmask;
      logic [1:0]              n_writes;
      logic [1:0]              wb_count;
      slot_t [NUM_SLOTS-1:0]   regs;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic [ENTRY_W-1:0]      w_head_raw;
   logic [CNT_W-1:0]        w_count;
   entry_t                  w_head;
   entry_t                  w_push_entry;
   entry_t                  w_head_upd;
   slot_t [NUM_SLOTS-1:0]   w_load_regs;
   logic [NUM_SLOTS-1:0]    w_load_en;
   logic                    w_empty;
   logic                    w_ready;
   logic                    w_commit_fire;
   logic                    w_head_done;
   logic                    w_wb_attach;
   logic                    w_wb_orphan;

   logic                    r_trace_valid;
   logic [ARCH_LEN-1:0]     r_trace_pc;
   logic [WARP_ID_BITS-1:0] r_trace_warp_id;
   logic [NUM_LANES-1:0]    r_trace_tmask;
   logic [NUM_SLOTS-1:0]    r_trace_en;
   slot_t [NUM_SLOTS-1:0]   r_trace_regs;
   logic [31:0]             r_trace_count;
   logic                    r_err_orphan_wb;

   cyclotron_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_push      (w_commit_fire),
      .i_push_data (w_push_entry),
      .i_pop       (w_head_done),
      .i_head_wr   (w_wb_attach),
      .i_head_data (w_head_upd),
      .o_head      (w_head_raw),
      .o_count     (w_count)
   );

   // Queue control: everything decided from registered occupancy and the registered head.
   always_comb begin
      w_head        = entry_t'(w_head_raw);
      w_empty       = (w_count == CNT_W'(0));
      w_ready       = (w_count < CNT_W'(DEPTH));
      w_commit_fire = bus.commit_valid && w_ready;
      w_head_done   = !w_empty && (w_head.wb_count == w_head.n_writes);
      w_wb_attach   = bus.wb_valid && !w_empty && (w_head.wb_count < w_head.n_writes);
      w_wb_orphan   = bus.wb_valid && !w_wb_attach;
   end

   // New queue entry built from the commit port; no writebacks captured yet.
   always_comb begin
      w_push_entry          = '0;
      w_push_entry.pc       = bus.commit_pc;
      w_push_entry.warp_id  = bus.commit_warpId;
      w_push_entry.tmask    = bus.commit_tmask;
      w_push_entry.n_writes = bus.commit_nWrites;
      w_push_entry.wb_count = 2'd0;
   end

   // Head rewrite: the writeback fills the next free slot and advances the count.
   always_comb begin
      w_head_upd = w_head;
      case (w_head.wb_count)
         2'd0:    w_head_upd.regs[0] = '{address: bus.wb_address, data: bus.wb_data};
         2'd1:    w_head_upd.regs[1] = '{address: bus.wb_address, data: bus.wb_data};
         2'd2:    w_head_upd.regs[2] = '{address: bus.wb_address, data: bus.wb_data};
         default: w_head_upd.regs[0] = w_head.regs[0];
      endcase
      w_head_upd.wb_count = w_head.wb_count + 2'd1;
   end

   // Record payload: slots beyond the expected write count are forced to zero.
   always_comb begin
      w_load_regs = w_head.regs;
      w_load_en   = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (slot_enabled(w_head.n_writes, 2'(k))) begin
            w_load_en[k] = 1'b1;
         end else begin
            w_load_en[k]   = 1'b0;
            w_load_regs[k] = '0;
         end
      end
   end

   // Trace output registers: loaded for exactly one cycle per popped entry, zero otherwise.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_trace_valid   <= 1'b0;
         r_trace_pc      <= '0;
         r_trace_warp_id <= '0;
         r_trace_tmask   <= '0;
         r_trace_en      <= '0;
         r_trace_regs    <= '0;
      end else if (w_head_done) begin
         r_trace_valid   <= 1'b1;
         r_trace_pc      <= w_head.pc;
         r_trace_warp_id <= w_head.warp_id;
         r_trace_tmask   <= w_head.tmask;
         r_trace_en      <= w_load_en;
         r_trace_regs    <= w_load_regs;
      end else begin
         r_trace_valid   <= 1'b0;
         r_trace_pc      <= '0;
         r_trace_warp_id <= '0;
         r_trace_tmask   <= '0;
         r_trace_en      <= '0;
         r_trace_regs    <= '0;
      end
   end

   // Emitted-record counter, free-running modulo 2^32.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_trace_count <= 32'd0;
      end else if (w_head_done) begin
         r_trace_count <= r_trace_count + 32'd1;
      end else begin
         r_trace_count <= r_trace_count;
      end
   end

   // Sticky flag for writebacks that found no head entry waiting for them.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_err_orphan_wb <= 1'b0;
      end else if (w_wb_orphan) begin
         r_err_orphan_wb <= 1'b1;
      end else begin
         r_err_orphan_wb <= r_err_orphan_wb;
      end
   end

   assign bus.commit_ready         = w_ready;
   assign bus.trace_valid          = r_trace_valid;
   assign bus.trace_pc             = r_trace_pc;
   assign bus.trace_warpId         = r_trace_warp_id;
   assign bus.trace_tmask          = r_trace_tmask;
   assign bus.trace_regs_0_enable  = r_trace_en[0];
   assign bus.trace_regs_0_address = r_trace_regs[0].address;
   assign bus.trace_regs_0_data    = r_trace_regs[0].data;
   assign bus.trace_regs_1_enable  = r_trace_en[1];
   assign bus.trace_regs_1_address = r_trace_regs[1].address;
   assign bus.trace_regs_1_data    = r_trace_regs[1].data;
   assign bus.trace_regs_2_enable  = r_trace_en[2];
   assign bus.trace_regs_2_address = r_trace_regs[2].address;
   assign bus.trace_regs_2_data    = r_trace_regs[2].data;
   assign bus.trace_count          = r_trace_count;
   assign bus.err_orphan_wb        = r_err_orphan_wb;

endmodule

// File: tb/tb_cyclotron_trace_collector.sv
// Directed, table-driven bench for the cyclotron trace collector (default parameters).
module tb_cyclotron_trace_collector;

   localparam int NL = 16;
   localparam int AL = 32;

   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   cyclotron_trace_collector_if bus ();

   cyclotron_trace_collector dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        cv;
      logic [31:0] pc;
      logic [2:0]  w;
      logic [15:0] tm;
      logic [1:0]  nw;
      logic        wv;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        ev;
      logic [31:0] epc;
      logic [2:0]  ew;
      logic [15:0] etm;
      logic [2:0]  een;
      logic [7:0]  ea0, ea1, ea2;
      logic [31:0] ed0, ed1, ed2;
      logic [31:0] ecnt;
      logic        erdy;
      logic        eerr;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [NL*AL-1:0] mk_data(input logic [31:0] v);
      logic [NL*AL-1:0] d;
      for (int g = 0; g < NL; g++) begin
         d[AL*g +: AL] = v + 32'(g);
      end
      return d;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic cv, input logic [31:0] pc, input logic [2:0] w,
                         input logic [15:0] tm, input logic [1:0] nw,
                         input logic wv, input logic [7:0] wa, input logic [31:0] wd);
      bus.commit_valid   = cv;
      bus.commit_pc      = pc;
      bus.commit_warpId  = w;
      bus.commit_tmask   = tm;
      bus.commit_nWrites = nw;
      bus.wb_valid       = wv;
      bus.wb_address     = wa;
      bus.wb_data        = mk_data(wd);
   endtask

   task automatic idle();
      set_in(1'b0, 32'h0, 3'd0, 16'h0, 2'd0, 1'b0, 8'h0, 32'h0);
   endtask

   task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [2:0] ew, input logic [15:0] etm, input logic [2:0] een,
                             input logic [7:0] ea0, input logic [7:0] ea1, input logic [7:0] ea2,
                             input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ed2,
                             input logic [31:0] ecnt, input logic erdy, input logic eerr);
      logic [NL*AL-1:0] x0, x1, x2;
      x0 = een[0] ? mk_data(ed0) : '0;
      x1 = een[1] ? mk_data(ed1) : '0;
      x2 = een[2] ? mk_data(ed2) : '0;
      check({tag, " trace_valid"}, 512'(bus.trace_valid), 512'(ev));
      check({tag, " trace_pc"}, 512'(bus.trace_pc), 512'(epc));
      check({tag, " trace_warpId"}, 512'(bus.trace_warpId), 512'(ew));
      check({tag, " trace_tmask"}, 512'(bus.trace_tmask), 512'(etm));
      check({tag, " enables"}, 512'({bus.trace_regs_2_enable, bus.trace_regs_1_enable,
                                      bus.trace_regs_0_enable}), 512'(een));
      check({tag, " addr0"}, 512'(bus.trace_regs_0_address), 512'(ea0));
      check({tag, " addr1"}, 512'(bus.trace_regs_1_address), 512'(ea1));
      check({tag, " addr2"}, 512'(bus.trace_regs_2_address), 512'(ea2));
      check({tag, " data0"}, bus.trace_regs_0_data, x0);
      check({tag, " data1"}, bus.trace_regs_1_data, x1);
      check({tag, " data2"}, bus.trace_regs_2_data, x2);
      check({tag, " trace_count"}, 512'(bus.trace_count), 512'(ecnt));
      check({tag, " commit_ready"}, 512'(bus.commit_ready), 512'(erdy));
      check({tag, " err_orphan_wb"}, 512'(bus.err_orphan_wb), 512'(eerr));
   endtask

   task automatic expect_idle(input string tag, input logic [31:0] ecnt, input logic erdy,
                              input logic eerr);
      expect_out(tag, 1'b0, 32'h0, 3'd0, 16'h0, 3'b000, 8'h0, 8'h0, 8'h0,
                 32'h0, 32'h0, 32'h0, ecnt, erdy, eerr);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      idle();

      //            cv    pc            w     tm        nw    wv    wa     wd        ev    epc           ew    etm       een     ea0    ea1    ea2    ed0       ed1       ed2       ecnt   rdy   err
      vecs[0]  = '{1'b1, 32'h8000_0000, 3'd3, 16'hFFFF, 2'd0, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b1, 32'h8000_0000, 3'd3, 16'hFFFF, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_1000, 3'd1, 16'h00FF, 2'd2, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b1, 8'h05, 32'h11, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b1, 8'h07, 32'h22, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b1, 32'h0000_1000, 3'd1, 16'h00FF, 3'b011, 8'h5, 8'h7, 8'h0, 32'h11, 32'h22, 32'h0,  32'd2, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd2, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_2000, 3'd7, 16'h0000, 2'd3, 1'b1, 8'h09, 32'h99, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd2, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 32'h0000_3000, 3'd2, 16'h0001, 2'd0, 1'b1, 8'h01, 32'hA1, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd2, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b1, 8'h02, 32'hA2, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd2, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b1, 8'h03, 32'hA3, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd2, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b1, 32'h0000_2000, 3'd7, 16'h0000, 3'b111, 8'h1, 8'h2, 8'h3, 32'hA1, 32'hA2, 32'hA3, 32'd3, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b1, 32'h0000_3000, 3'd2, 16'h0001, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd4, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b0, 8'h00, 32'h00, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd4, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 32'h0,         3'd0, 16'h0000, 2'd0, 1'b1, 8'h0E, 32'h0E, 1'b0, 32'h0,         3'd0, 16'h0000, 3'b000, 8'h0, 8'h0, 8'h0, 32'h0,  32'h0,  32'h0,  32'd4, 1'b1, 1'b1};

      // Reset state.
      for (int i = 0; i < 3; i++) step();
      expect_idle("reset", 32'd0, 1'b1, 1'b0);
      reset_n = 1'b1;
      step();
      expect_idle("post_reset", 32'd0, 1'b1, 1'b0);

      // Table: latency, slot fill, tmask=0, orphan writeback, commit order.
      for (int i = 0; i < 17; i++) begin
         set_in(vecs[i].cv, vecs[i].pc, vecs[i].w, vecs[i].tm, vecs[i].nw,
                vecs[i].wv, vecs[i].wa, vecs[i].wd);
         step();
         expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ew, vecs[i].etm,
                    vecs[i].een, vecs[i].ea0, vecs[i].ea1, vecs[i].ea2,
                    vecs[i].ed0, vecs[i].ed1, vecs[i].ed2, vecs[i].ecnt, vecs[i].erdy,
                    vecs[i].eerr);
      end

      // Full queue: four single-write commits, ready drops, then drain in order.
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 32'h100 + 32'(4 * k), 3'(k), 16'hAAAA, 2'd1, 1'b0, 8'h0, 32'h0);
         step();
         expect_idle($sformatf("fill%0d", k), 32'd4, (k < 3) ? 1'b1 : 1'b0, 1'b1);
      end
      set_in(1'b0, 32'h0, 3'd0, 16'h0, 2'd0, 1'b1, 8'h01, 32'h55);
      step();
      expect_idle("full_wb", 32'd4, 1'b0, 1'b1);
      idle();
      step();
      expect_out("full_pop0", 1'b1, 32'h100, 3'd0, 16'hAAAA, 3'b001, 8'h01, 8'h0, 8'h0,
                 32'h55, 32'h0, 32'h0, 32'd5, 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) begin
         set_in(1'b0, 32'h0, 3'd0, 16'h0, 2'd0, 1'b1, 8'(i + 1), 32'h55 + 32'(i));
         step();
         expect_idle($sformatf("drain_wb%0d", i), 32'(4 + i), 1'b1, 1'b1);
         if (i == 3) begin
            set_in(1'b1, 32'h300, 3'd5, 16'h5555, 2'd0, 1'b0, 8'h0, 32'h0);
         end else begin
            idle();
         end
         step();
         expect_out($sformatf("drain_pop%0d", i), 1'b1, 32'h100 + 32'(4 * i), 3'(i), 16'hAAAA,
                    3'b001, 8'(i + 1), 8'h0, 8'h0, 32'h55 + 32'(i), 32'h0, 32'h0,
                    32'(5 + i), 1'b1, 1'b1);
      end
      idle();
      step();
      expect_out("push_pop_rec", 1'b1, 32'h300, 3'd5, 16'h5555, 3'b000, 8'h0, 8'h0, 8'h0,
                 32'h0, 32'h0, 32'h0, 32'd9, 1'b1, 1'b1);
      step();
      expect_idle("drained", 32'd9, 1'b1, 1'b1);

      // Reset with three pending entries; inputs during reset are ignored.
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'h400 + 32'(4 * k), 3'd0, 16'hFFFF, 2'd1, 1'b0, 8'h0, 32'h0);
         step();
         expect_idle($sformatf("pend%0d", k), 32'd9, 1'b1, 1'b1);
      end
      reset_n = 1'b0;
      set_in(1'b1, 32'h500, 3'd1, 16'h1, 2'd0, 1'b1, 8'h9, 32'h9);
      for (int k = 0; k < 2; k++) begin
         step();
         expect_idle($sformatf("in_reset%0d", k), 32'd0, 1'b1, 1'b0);
      end
      reset_n = 1'b1;
      idle();
      for (int k = 0; k < 3; k++) begin
         step();
         expect_idle($sformatf("discarded%0d", k), 32'd0, 1'b1, 1'b0);
      end
      set_in(1'b1, 32'h600, 3'd4, 16'h0F0F, 2'd0, 1'b0, 8'h0, 32'h0);
      step();
      expect_idle("fresh_commit", 32'd0, 1'b1, 1'b0);
      idle();
      step();
      expect_out("fresh_rec", 1'b1, 32'h600, 3'd4, 16'h0F0F, 3'b000, 8'h0, 8'h0, 8'h0,
                 32'h0, 32'h0, 32'h0, 32'd1, 1'b1, 1'b0);

      // Counter wrap from all-ones.
      force dut.r_trace_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_trace_count;
      set_in(1'b1, 32'h700, 3'd6, 16'h1234, 2'd1, 1'b0, 8'h0, 32'h0);
      step();
      expect_idle("wrap_commit", 32'hFFFF_FFFF, 1'b1, 1'b0);
      set_in(1'b0, 32'h0, 3'd0, 16'h0, 2'd0, 1'b1, 8'h3F, 32'h77);
      step();
      expect_idle("wrap_wb", 32'hFFFF_FFFF, 1'b1, 1'b0);
      idle();
      step();
      expect_out("wrap_rec", 1'b1, 32'h700, 3'd6, 16'h1234, 3'b001, 8'h3F, 8'h0, 8'h0,
                 32'h77, 32'h0, 32'h0, 32'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
